// File: rtl/banco_regs_param_if.sv
// Bus bundle for banco_regs_param: read ports, writeback and reservation
// signals, plus the pending-count output.
interface banco_regs_param_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);
    logic [NUM_READ*ADDR_W-1:0] rl;
    logic [NUM_READ*DATA_W-1:0] d;
    logic [NUM_READ-1:0]        pronto;
    logic                       h_esc;
    logic [ADDR_W-1:0]          resc;
    logic [DATA_W-1:0]          dado;
    logic                       h_res;
    logic [ADDR_W-1:0]          rres;
    logic [ADDR_W:0]            n_pend;

    modport master (
        output rl, h_esc, resc, dado, h_res, rres,
        input  d, pronto, n_pend
    );

    modport slave (
        input  rl, h_esc, resc, dado, h_res, rres,
        output d, pronto, n_pend
    );
endinterface

// File: rtl/banco_regs_param.sv
// Parametrised register bank: hardwired-zero x0, optional write-to-read
// forwarding, stack-pointer reset value and a pending-write scoreboard.
module banco_regs_param #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_REGS = 32,
    parameter int                NUM_READ = 2,
    parameter int                BYPASS   = 1,
    parameter int                SP_IDX   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = '0
) (
    input logic          clk,
    input logic          rst_n,
    banco_regs_param_if.slave bus
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]          regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]        busy;
    logic [NUM_REGS-1:1]        busy_nxt;
    logic [ADDR_W:0]            n_pend_q;
    logic                       wr_ok;
    logic                       res_ok;
    logic                       inc;
    logic                       dec;
    logic [NUM_READ*DATA_W-1:0] d_v;
    logic [NUM_READ-1:0]        pronto_v;

    assign wr_ok  = bus.h_esc && (bus.resc != '0) && ({1'b0, bus.resc} < NUM_REGS_W);
    assign res_ok = bus.h_res && (bus.rres != '0) && ({1'b0, bus.rres} < NUM_REGS_W);

    // Reserve is applied after the write clear so a same-cycle producer wins.
    always_comb begin
        busy_nxt = busy;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_ok && bus.resc == ADDR_W'(i))
                busy_nxt[i] = 1'b0;
            if (res_ok && bus.rres == ADDR_W'(i))
                busy_nxt[i] = 1'b1;
            if (!busy[i] && busy_nxt[i])
                inc = 1'b1;
            if (busy[i] && !busy_nxt[i])
                dec = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            busy     <= '0;
            n_pend_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++)
                if (wr_ok && bus.resc == ADDR_W'(i))
                    regs[i] <= bus.dado;
            busy     <= busy_nxt;
            n_pend_q <= n_pend_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        end
    end

    // Out-of-range and x0 addresses fall through the decode with d=0, ready.
    always_comb begin
        d_v      = '0;
        pronto_v = '1;
        for (int p = 0; p < NUM_READ; p++) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (bus.rl[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    d_v[p*DATA_W +: DATA_W] = regs[i];
                    pronto_v[p]             = !busy[i];
                end
            end
            if (BYPASS != 0 && wr_ok && bus.rl[p*ADDR_W +: ADDR_W] == bus.resc) begin
                d_v[p*DATA_W +: DATA_W] = bus.dado;
                pronto_v[p]             = 1'b1;
            end
        end
    end

    assign bus.d      = d_v;
    assign bus.pronto = pronto_v;
    assign bus.n_pend = n_pend_q;

endmodule

// File: tb/tb_banco_regs_param.sv
// Scoreboard bench: two banks (forwarding 32 regs, stored-read 24 regs) share
// stimulus and are compared against an array-based reference model.
module tb_banco_regs_param;

    localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        h_esc, h_res;
    logic [4:0]  resc, rres, rl0, rl1;
    logic [31:0] dado;

    banco_regs_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) ifa ();
    banco_regs_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) ifb ();

    assign ifa.rl = {rl1, rl0};  assign ifb.rl = {rl1, rl0};
    assign ifa.h_esc = h_esc;    assign ifb.h_esc = h_esc;
    assign ifa.resc = resc;      assign ifb.resc = resc;
    assign ifa.dado = dado;      assign ifb.dado = dado;
    assign ifa.h_res = h_res;    assign ifb.h_res = h_res;
    assign ifa.rres = rres;      assign ifb.rres = rres;

    banco_regs_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_READ(2),
                       .BYPASS(1), .SP_IDX(2), .SP_RESET(SP_VAL))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    banco_regs_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .NUM_READ(2),
                       .BYPASS(0), .SP_IDX(2), .SP_RESET(SP_VAL))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // reference model
    int          nregs [2] = '{32, 24};
    bit          byp   [2] = '{1'b1, 1'b0};
    logic [31:0] mem   [2][32];
    bit          bsy   [2][32];

    typedef struct {
        int          dut;
        logic [31:0] d0, d1;
        logic [1:0]  pr;
        logic [5:0]  np;
    } exp_t;
    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    endtask

    function automatic void model_read(input int u, input logic [4:0] a,
                                       output logic [31:0] dv, output logic pv);
        if (a == 0 || int'(a) >= nregs[u]) begin
            dv = 0; pv = 1'b1;
        end else if (byp[u] && h_esc && resc == a) begin
            dv = dado; pv = 1'b1;
        end else begin
            dv = mem[u][a]; pv = !bsy[u][a];
        end
    endfunction

    function automatic int popcount(input int u);
        int c = 0;
        for (int i = 0; i < 32; i++) if (bsy[u][i]) c++;
        return c;
    endfunction

    function automatic void model_edge(input int u);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[u][i] = 0; bsy[u][i] = 0;
            end
            mem[u][2] = SP_VAL;
        end else begin
            if (h_esc && resc != 0 && int'(resc) < nregs[u]) begin
                mem[u][resc] = dado; bsy[u][resc] = 0;
            end
            if (h_res && rres != 0 && int'(rres) < nregs[u])
                bsy[u][rres] = 1;
        end
    endfunction

    task automatic step(input bit r, input bit he, input logic [4:0] wa, input logic [31:0] wd,
                        input bit hr, input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1);
        exp_t e;
        logic p0, p1;
        rst_n = r; h_esc = he; resc = wa; dado = wd; h_res = hr; rres = ra; rl0 = a0; rl1 = a1;
        for (int u = 0; u < 2; u++) begin
            e.dut = u;
            model_read(u, a0, e.d0, p0);
            model_read(u, a1, e.d1, p1);
            e.pr = {p1, p0};
            e.np = 6'(popcount(u));
            q.push_back(e);
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            string s;
            e = q.pop_front();
            s = (e.dut == 0) ? "a" : "b";
            if (e.dut == 0) begin
                chk({s, ".d0"},     ifa.d[31:0],           e.d0);
                chk({s, ".d1"},     ifa.d[63:32],          e.d1);
                chk({s, ".pronto"}, {30'b0, ifa.pronto},   {30'b0, e.pr});
                chk({s, ".n_pend"}, {26'b0, ifa.n_pend},   {26'b0, e.np});
            end else begin
                chk({s, ".d0"},     ifb.d[31:0],           e.d0);
                chk({s, ".d1"},     ifb.d[63:32],          e.d1);
                chk({s, ".pronto"}, {30'b0, ifb.pronto},   {30'b0, e.pr});
                chk({s, ".n_pend"}, {26'b0, ifb.n_pend},   {26'b0, e.np});
            end
        end
    end

    initial begin
        // reset with a write attempt to x7 that must be discarded
        rst_n = 0; h_esc = 1; resc = 7; dado = 32'hFFFF_FFFF; h_res = 1; rres = 8; rl0 = 2; rl1 = 5;
        @(posedge clk);
        model_edge(0); model_edge(1);
        #1;

        step(1, 0, 0,  0,            0, 0,  2,  5);
        step(1, 0, 0,  0,            0, 0,  7,  8);
        step(1, 1, 0,  32'hDEAD_BEEF, 0, 0, 0,  0);
        step(1, 1, 31, 32'h1234_5678, 0, 0, 0,  31);
        step(1, 0, 0,  0,            0, 0, 31,  0);
        step(1, 1, 5,  32'h11,       0, 0,  5,  0);
        step(1, 1, 5,  32'h22,       0, 0,  5,  5);
        step(1, 0, 0,  0,            0, 0,  5,  0);
        step(1, 0, 0,  0,            1, 3,  3,  4);
        step(1, 0, 0,  0,            1, 4,  3,  4);
        step(1, 0, 0,  0,            1, 3,  3,  4);
        step(1, 1, 3,  32'h33,       0, 0,  3,  4);
        step(1, 0, 0,  0,            0, 0,  3,  4);
        step(1, 1, 9,  32'h99,       1, 9,  9,  3);
        step(1, 0, 0,  0,            1, 3,  9,  3);
        step(1, 1, 3,  32'h333,      1, 10, 3, 10);
        step(1, 0, 0,  0,            0, 0, 10,  3);
        step(1, 1, 23, 32'h2323,     1, 23, 23, 22);
        step(1, 0, 0,  0,            0, 0, 23,  9);
        step(0, 0, 0,  0,            1, 6,  6,  9);
        step(1, 0, 0,  0,            0, 0,  2,  9);
        step(1, 0, 0,  0,            0, 0,  4, 10);

        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 59) != 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
